// File: rtl/wb_pkg.sv
// Shared types and defaults for the Wishbone master mux and its bus watchdog.
package wb_pkg;

    typedef enum logic [1:0] {
        WD_IDLE  = 2'd0,
        WD_WAIT  = 2'd1,
        WD_ABORT = 2'd2
    } wd_state_e;

    localparam int WB_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts unanswered strobe cycles, fires an error at the limit
// and holds the slave request off for one ABORT cycle afterwards.
module wb_watchdog
    import wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             s_stb_o,
    input  logic             s_ack_i,
    input  logic             s_err_i,
    output logic             wd_fire,
    output logic             abort,
    output wd_state_e        state,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic pending;

    assign pending = s_stb_o & ~s_ack_i & ~s_err_i;
    // A response in the limit cycle masks the fire, so ack wins over timeout.
    assign wd_fire = pending & (cnt == CNT_LIMIT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= WD_IDLE;
            cnt   <= '0;
            abort <= 1'b0;
        end else begin
            abort <= 1'b0;
            case (state)
                WD_IDLE: begin
                    if (pending) begin
                        state <= WD_WAIT;
                        cnt   <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                    end
                end
                WD_WAIT: begin
                    if (wd_fire) begin
                        state <= WD_ABORT;
                        cnt   <= '0;
                        abort <= 1'b1;
                    end else if (pending) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        state <= WD_IDLE;
                        cnt   <= '0;
                    end
                end
                WD_ABORT: begin
                    state <= WD_IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state <= WD_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/wb_master_mux.sv
// Routes the granted master's classic Wishbone request to the single slave port.
// Optional bus watchdog enabled with `define WB_MUX_WATCHDOG_EN.
module wb_master_mux
    import wb_pkg::*;
#(
    parameter int MASTER_COUNT   = 2,
    parameter int GNT_WIDTH      = $clog2(MASTER_COUNT),
    parameter int ADDR_WIDTH     = 24,
    parameter int DATA_WIDTH     = 8,
    parameter int SEL_WIDTH      = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [GNT_WIDTH-1:0]             gnt_i,
    input  logic                             cyc_i,
    input  logic [MASTER_COUNT-1:0]          m_cyc_i,
    input  logic [MASTER_COUNT-1:0]          m_stb_i,
    input  logic [MASTER_COUNT-1:0]          m_we_i,
    input  logic [MASTER_COUNT*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [MASTER_COUNT*DATA_WIDTH-1:0] m_dat_i,
    input  logic [MASTER_COUNT*SEL_WIDTH-1:0]  m_sel_i,
    output logic [DATA_WIDTH-1:0]            m_dat_o,
    output logic [MASTER_COUNT-1:0]          m_ack_o,
    output logic [MASTER_COUNT-1:0]          m_err_o,
    output logic                             s_cyc_o,
    output logic                             s_stb_o,
    output logic                             s_we_o,
    output logic [ADDR_WIDTH-1:0]            s_adr_o,
    output logic [DATA_WIDTH-1:0]            s_dat_o,
    output logic [SEL_WIDTH-1:0]             s_sel_o,
    input  logic [DATA_WIDTH-1:0]            s_dat_i,
    input  logic                             s_ack_i,
    input  logic                             s_err_i,
    output logic                             timeout_o
);

    logic [ADDR_WIDTH-1:0] adr_a [MASTER_COUNT];
    logic [DATA_WIDTH-1:0] dat_a [MASTER_COUNT];
    logic [SEL_WIDTH-1:0]  sel_a [MASTER_COUNT];
    logic                  wd_fire;
    logic                  abort;
    logic                  unused_ok;

    for (genvar i = 0; i < MASTER_COUNT; i++) begin : g_unpack
        assign adr_a[i] = m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign dat_a[i] = m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
        assign sel_a[i] = m_sel_i[i*SEL_WIDTH +: SEL_WIDTH];
    end

    // The ABORT cycle drops the slave cycle so the hung peripheral sees a terminated transfer.
    assign s_cyc_o = cyc_i & m_cyc_i[gnt_i] & ~abort;
    assign s_stb_o = s_cyc_o & m_stb_i[gnt_i];
    assign s_we_o  = m_we_i[gnt_i];
    assign s_adr_o = adr_a[gnt_i];
    assign s_dat_o = dat_a[gnt_i];
    assign s_sel_o = sel_a[gnt_i];

    assign m_dat_o   = s_dat_i;
    assign timeout_o = wd_fire;

    // Responses are qualified by our own strobe so stale or late acks never leak out.
    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        m_ack_o[gnt_i] = s_ack_i & s_stb_o;
        m_err_o[gnt_i] = (s_err_i & s_stb_o) | wd_fire;
    end

`ifdef WB_MUX_WATCHDOG_EN
    wd_state_e                         wd_state;
    logic [$clog2(TIMEOUT_CYCLES)-1:0] wd_cnt;

    wb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wd (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .s_stb_o (s_stb_o),
        .s_ack_i (s_ack_i),
        .s_err_i (s_err_i),
        .wd_fire (wd_fire),
        .abort   (abort),
        .state   (wd_state),
        .cnt     (wd_cnt)
    );

    assign unused_ok = ^{wd_state, wd_cnt};
`else
    assign wd_fire   = 1'b0;
    assign abort     = 1'b0;
    assign unused_ok = &{1'b0, clk_i, rst_i, (TIMEOUT_CYCLES > 0)};
`endif

endmodule

// File: tb/tb_wb_master_mux.sv
// Self-checking bench for wb_master_mux (TIMEOUT_CYCLES = 4).
module tb_wb_master_mux;
    import wb_pkg::*;

    localparam int MC    = 2;
    localparam int AW    = 24;
    localparam int DW    = 8;
    localparam int SW    = 1;
    localparam int TO    = 4;
    localparam int RSP_W = 2 * MC + DW;

    logic             clk = 1'b0;
    logic             rst;
    logic             gnt;
    logic             cyc;
    logic [MC-1:0]    m_cyc, m_stb, m_we;
    logic [MC*AW-1:0] m_adr;
    logic [MC*DW-1:0] m_dat;
    logic [MC*SW-1:0] m_sel;
    logic [DW-1:0]    m_dat_o;
    logic [MC-1:0]    m_ack_o, m_err_o;
    logic             s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]    s_adr_o;
    logic [DW-1:0]    s_dat_o;
    logic [SW-1:0]    s_sel_o;
    logic [DW-1:0]    s_dat;
    logic             s_ack, s_err;
    logic             timeout_o;

    logic [RSP_W-1:0] exp_q[$];
    int               n_checks = 0;
    int               n_pass   = 0;

    wb_master_mux #(
        .MASTER_COUNT  (MC),
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .gnt_i    (gnt),
        .cyc_i    (cyc),
        .m_cyc_i  (m_cyc),
        .m_stb_i  (m_stb),
        .m_we_i   (m_we),
        .m_adr_i  (m_adr),
        .m_dat_i  (m_dat),
        .m_sel_i  (m_sel),
        .m_dat_o  (m_dat_o),
        .m_ack_o  (m_ack_o),
        .m_err_o  (m_err_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_sel_o  (s_sel_o),
        .s_dat_i  (s_dat),
        .s_ack_i  (s_ack),
        .s_err_i  (s_err),
        .timeout_o(timeout_o)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive_master(input int idx, input logic we, input logic [AW-1:0] adr,
                                input logic [DW-1:0] dat);
        m_cyc[idx]           = 1'b1;
        m_stb[idx]           = 1'b1;
        m_we[idx]            = we;
        m_adr[idx*AW +: AW]  = adr;
        m_dat[idx*DW +: DW]  = dat;
        m_sel[idx*SW +: SW]  = 1'b1;
    endtask

    task automatic idle_bus();
        cyc   = 1'b0;
        m_cyc = '0;
        m_stb = '0;
        s_ack = 1'b0;
        s_err = 1'b0;
        tick();
    endtask

    // Scoreboard: every response seen by a master must match the queue head
    always @(negedge clk) begin
        if ((m_ack_o | m_err_o) != '0) begin
            if (exp_q.size() == 0) check("rsp_unexpected", {m_ack_o, m_err_o, m_dat_o}, '0);
            else check("rsp", {m_ack_o, m_err_o, m_dat_o}, exp_q.pop_front());
        end
    end

    initial begin
        rst = 1'b1; gnt = 1'b0; cyc = 1'b0;
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '0;
        s_dat = '0; s_ack = 1'b0; s_err = 1'b0;
        tick(); tick();
        sample();
        check("reset_outs", {m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, timeout_o}, '0);
        tick();
        rst = 1'b0;
        tick();

        // Master 1 write, ack in cycle 2; master 0 carries decoy fields
        gnt = 1'b1; cyc = 1'b1;
        m_adr[0 +: AW] = 24'hABCDEF; m_dat[0 +: DW] = 8'h11; m_we[0] = 1'b0;
        drive_master(1, 1'b1, 24'h000010, 8'h5A);
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin
                s_ack = 1'b1;
                exp_q.push_back({2'b10, 2'b00, 8'h00});
            end
            sample();
            check("wr_fields", {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o},
                  {3'b111, 24'h000010, 8'h5A});
            if (c < 2) check("wr_no_ack", m_ack_o, 2'b00);
            tick();
        end
        idle_bus();

        // Master 0 read returning 0xC3
        gnt = 1'b0; cyc = 1'b1; s_dat = 8'hC3;
        drive_master(0, 1'b0, 24'h123456, 8'h00);
        sample();
        check("rd_fields", {s_we_o, s_adr_o}, {1'b0, 24'h123456});
        tick();
        s_ack = 1'b1;
        exp_q.push_back({2'b01, 2'b00, 8'hC3});
        sample();
        check("rd_data", m_dat_o, 8'hC3);
        tick();
        idle_bus();

        // Slave error on master 1
        gnt = 1'b1; cyc = 1'b1; s_dat = 8'h3C; s_err = 1'b1;
        drive_master(1, 1'b0, 24'h000400, 8'h00);
        exp_q.push_back({2'b00, 2'b10, 8'h3C});
        sample();
        tick();
        idle_bus();

        // Unanswered strobe
        gnt = 1'b0; cyc = 1'b1; s_dat = 8'h77;
        drive_master(0, 1'b0, 24'h000200, 8'h00);
`ifdef WB_MUX_WATCHDOG_EN
        for (int c = 0; c < 6; c++) begin
            if (c == 3) exp_q.push_back({2'b00, 2'b01, 8'h77});
            s_ack = (c == 4);
            sample();
            if (c < 3) check("to_pre", {timeout_o, m_err_o, s_stb_o}, 4'b0001);
            if (c == 3) check("to_fire", timeout_o, 1'b1);
            if (c == 4) check("to_abort", {s_cyc_o, s_stb_o, m_ack_o, timeout_o}, '0);
            if (c == 5) check("to_resume", {s_cyc_o, s_stb_o}, 2'b11);
            tick();
        end
`else
        for (int c = 0; c < 6; c++) begin
            sample();
            check("nowd_hold", {timeout_o, m_err_o, s_cyc_o, s_stb_o}, 5'b00011);
            tick();
        end
`endif
        idle_bus();

        // Ack exactly in the limit cycle wins over the timeout
        gnt = 1'b0; cyc = 1'b1; s_dat = 8'h99;
        drive_master(0, 1'b1, 24'h000300, 8'h42);
        for (int c = 0; c < 5; c++) begin
            s_ack = (c == TO - 1);
            if (c == TO - 1) exp_q.push_back({2'b01, 2'b00, 8'h99});
            sample();
            if (c == TO - 1) check("lim_no_to", timeout_o, 1'b0);
            if (c == TO) check("lim_no_abort", {s_cyc_o, s_stb_o}, 2'b11);
            tick();
        end
        idle_bus();

        // Ack with cyc_i low must not reach any master
        gnt = 1'b0; cyc = 1'b0; s_ack = 1'b1;
        drive_master(0, 1'b0, 24'h000500, 8'h00);
        sample();
        check("nocyc_ack", {m_ack_o, s_cyc_o, s_stb_o}, '0);
        tick();
        idle_bus();

        // Reset during a pending strobe
        gnt = 1'b1; cyc = 1'b1;
        drive_master(1, 1'b0, 24'h000600, 8'h00);
        for (int c = 0; c < 6; c++) begin
            rst = (c == 2);
            sample();
`ifdef WB_MUX_WATCHDOG_EN
            if (c == 3) check("rst_wd", {30'd0, dut.wd_state == WD_IDLE, dut.wd_cnt == '0}, 2'b11);
`endif
            check("rst_no_err", {m_err_o, timeout_o}, '0);
            tick();
        end
        rst = 1'b0;
        idle_bus();

        // Random transactions, answered before the limit
        for (int n = 0; n < 8; n++) begin
            automatic int              mi  = $urandom_range(0, 1);
            automatic int              dly = $urandom_range(0, 2);
            automatic logic            we  = 1'($urandom_range(0, 1));
            automatic logic [AW-1:0]   adr = AW'($urandom_range(0, 32'hFFFFFF));
            automatic logic [DW-1:0]   dat = DW'($urandom_range(0, 255));
            automatic logic [DW-1:0]   rd  = DW'($urandom_range(0, 255));
            gnt = 1'(mi); cyc = 1'b1;
            m_adr[(1-mi)*AW +: AW] = ~adr;
            m_dat[(1-mi)*DW +: DW] = ~dat;
            drive_master(mi, we, adr, dat);
            for (int c = 0; c <= dly; c++) begin
                if (c == dly) begin
                    s_ack = 1'b1;
                    s_dat = rd;
                    exp_q.push_back({(mi == 1) ? 2'b10 : 2'b01, 2'b00, rd});
                end
                sample();
                if (c == 0) check("rnd_fields", {s_we_o, s_adr_o, s_dat_o}, {we, adr, dat});
                tick();
            end
            idle_bus();
        end

        tick();
        check("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
